dsp_post_adder_acc: RTL and testbench

//   Post-adder/accumulator stage of the DSP48A1 slice model; consumes the registered multiplier

---
 rtl/dsp_post_adder_acc_pkg.sv | 35 +++
 rtl/dsp_post_adder_acc_ff_mux.sv | 35 +++
 rtl/dsp_post_adder_acc.sv | 123 ++++++++++++
 tb/tb_dsp_post_adder_acc.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/dsp_post_adder_acc_pkg.sv
// Shared definitions for the DSP48A1 post-adder/accumulator stage.
// OPMODE field positions, X/Z select codes and default widths.
package dsp_post_adder_acc_pkg;

  localparam int W_P_DEF = 48;
  localparam int W_M_DEF = 36;

  localparam int OPM_X_LSB = 0;
  localparam int OPM_Z_LSB = 2;
  localparam int OPM_CIN   = 5;
  localparam int OPM_SUB   = 7;

  typedef enum logic [1:0] {
    XSEL_ZERO = 2'd0,
    XSEL_M    = 2'd1,
    XSEL_P    = 2'd2,
    XSEL_DAB  = 2'd3
  } xsel_e;

  typedef enum logic [1:0] {
    ZSEL_ZERO = 2'd0,
    ZSEL_PCIN = 2'd1,
    ZSEL_P    = 2'd2,
    ZSEL_C    = 2'd3
  } zsel_e;

  function automatic xsel_e opm_xsel(input logic [7:0] opm);
    return xsel_e'(opm[OPM_X_LSB +: 2]);
  endfunction

  function automatic zsel_e opm_zsel(input logic [7:0] opm);
    return zsel_e'(opm[OPM_Z_LSB +: 2]);
  endfunction

endpackage

// File: rtl/dsp_post_adder_acc_ff_mux.sv
// Optional pipeline register with clock enable and reset.
// SEL=1 registers the input, SEL=0 passes it straight through.
module FF_Mux #(
  parameter int    W       = 1,
  parameter string RSTTYPE = "SYNC",
  parameter int    SEL     = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_ce,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  if (SEL != 0) begin : g_reg
    logic [W-1:0] r_q;
    if (RSTTYPE == "ASYNC") begin : g_async
      // Register with asynchronous clear; reset beats enable
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)     r_q <= '0;
        else if (i_ce) r_q <= i_d;
      end
    end else begin : g_sync
      // Register with synchronous clear; reset beats enable
      always_ff @(posedge i_clk) begin
        if (i_rst)     r_q <= '0;
        else if (i_ce) r_q <= i_d;
      end
    end
    assign o_q = r_q;
  end else begin : g_comb
    assign o_q = i_d;
  end

endmodule

// File: rtl/dsp_post_adder_acc.sv
// DSP48A1 post-adder/accumulator: X/Z operand muxes, 49-bit
// add/subtract with carry-in, registered P and CARRYOUT.
module dsp_post_adder_acc
  import dsp_post_adder_acc_pkg::*;
#(
  parameter int    W_P         = W_P_DEF,
  parameter int    W_M         = W_M_DEF,
  parameter int    OPMODEREG   = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    PREG        = 1,
  parameter int    CARRYOUTREG = 1,
  parameter string CARRYINSEL  = "OPMODE5"
) (
  input  logic           CLK,
  input  logic           rst,
  input  logic           CEOPMODE,
  input  logic           CECARRYIN,
  input  logic           CEP,
  input  logic           CECARRYOUT,
  input  logic [7:0]     OPMODE,
  input  logic [W_M-1:0] M,
  input  logic [W_P-1:0] DAB,
  input  logic [W_P-1:0] C,
  input  logic [W_P-1:0] PCIN,
  input  logic           CARRYIN,
  output logic [W_P-1:0] P,
  output logic [W_P-1:0] PCOUT,
  output logic           CARRYOUT,
  output logic           CARRYOUTF
);

  localparam bit CIN_EXT = (CARRYINSEL == "CARRYIN");

  logic [7:0]     w_opmode;
  logic           w_cin_sel;
  logic           w_cin;
  xsel_e          w_xsel;
  zsel_e          w_zsel;
  logic [W_P-1:0] w_fb;
  logic [W_P-1:0] w_x;
  logic [W_P-1:0] w_z;
  logic [W_P:0]   w_sum;
  logic [W_P-1:0] w_p;
  logic           w_co;
  logic           w_unused;

  FF_Mux #(.W(8), .RSTTYPE("SYNC"), .SEL(OPMODEREG)) u_opmode (
    .i_clk(CLK), .i_rst(rst), .i_ce(CEOPMODE),
    .i_d(OPMODE), .o_q(w_opmode)
  );

  assign w_cin_sel = CIN_EXT ? CARRYIN : w_opmode[OPM_CIN];

  FF_Mux #(.W(1), .RSTTYPE("SYNC"), .SEL(CARRYINREG)) u_cin (
    .i_clk(CLK), .i_rst(rst), .i_ce(CECARRYIN),
    .i_d(w_cin_sel), .o_q(w_cin)
  );

  assign w_xsel = opm_xsel(w_opmode);
  assign w_zsel = opm_zsel(w_opmode);

  // Without a P register the feedback path would be a combinational
  // loop; it is cut here and the illegal select is flagged below.
  assign w_fb = (PREG != 0) ? w_p : '0;

  // X operand select
  always_comb begin
    w_x = '0;
    unique case (w_xsel)
      XSEL_ZERO: w_x = '0;
      XSEL_M:    w_x = {{(W_P-W_M){1'b0}}, M};
      XSEL_P:    w_x = w_fb;
      XSEL_DAB:  w_x = DAB;
    endcase
  end

  // Z operand select
  always_comb begin
    w_z = '0;
    unique case (w_zsel)
      ZSEL_ZERO: w_z = '0;
      ZSEL_PCIN: w_z = PCIN;
      ZSEL_P:    w_z = w_fb;
      ZSEL_C:    w_z = C;
    endcase
  end

  // 49-bit add/subtract; the top bit is carry, or borrow on subtract
  always_comb begin
    w_sum = '0;
    if (w_opmode[OPM_SUB])
      w_sum = {1'b0, w_z} - ({1'b0, w_x} + {{W_P{1'b0}}, w_cin});
    else
      w_sum = {1'b0, w_z} + {1'b0, w_x} + {{W_P{1'b0}}, w_cin};
  end

  FF_Mux #(.W(W_P), .RSTTYPE("SYNC"), .SEL(PREG)) u_p (
    .i_clk(CLK), .i_rst(rst), .i_ce(CEP),
    .i_d(w_sum[W_P-1:0]), .o_q(w_p)
  );

  FF_Mux #(.W(1), .RSTTYPE("SYNC"), .SEL(CARRYOUTREG)) u_co (
    .i_clk(CLK), .i_rst(rst), .i_ce(CECARRYOUT),
    .i_d(w_sum[W_P]), .o_q(w_co)
  );

  assign P         = w_p;
  assign PCOUT     = w_p;
  assign CARRYOUT  = w_co;
  assign CARRYOUTF = w_co;

  // OPMODE[4] and OPMODE[6] carry no meaning in this stage
  assign w_unused = ^{w_opmode[6], w_opmode[4]};

  if (PREG == 0) begin : g_fb_chk
    // P feedback requested while P is not registered
    always_comb begin
      assert (w_xsel != XSEL_P && w_zsel != ZSEL_P)
        else $error("P feedback selected with PREG=0");
    end
  end

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// Scoreboard bench for dsp_post_adder_acc: expected P/CARRYOUT
// pushed with their due cycle, popped and compared when due.
module tb_dsp_post_adder_acc;

  localparam int W_P = 48;
  localparam int W_M = 36;

  logic           CLK;
  logic           rst;
  logic           CEOPMODE;
  logic           CECARRYIN;
  logic           CEP;
  logic           CECARRYOUT;
  logic [7:0]     OPMODE;
  logic [W_M-1:0] M;
  logic [W_P-1:0] DAB;
  logic [W_P-1:0] C;
  logic [W_P-1:0] PCIN;
  logic           CARRYIN;

  logic [W_P-1:0] p0, pc0, p1, pc1;
  logic           co0, cof0, co1, cof1;

  dsp_post_adder_acc u_dut0 (
    .CLK(CLK), .rst(rst),
    .CEOPMODE(CEOPMODE), .CECARRYIN(CECARRYIN),
    .CEP(CEP), .CECARRYOUT(CECARRYOUT),
    .OPMODE(OPMODE), .M(M), .DAB(DAB), .C(C),
    .PCIN(PCIN), .CARRYIN(CARRYIN),
    .P(p0), .PCOUT(pc0), .CARRYOUT(co0), .CARRYOUTF(cof0)
  );

  dsp_post_adder_acc #(.CARRYINSEL("CARRYIN")) u_dut1 (
    .CLK(CLK), .rst(rst),
    .CEOPMODE(CEOPMODE), .CECARRYIN(CECARRYIN),
    .CEP(CEP), .CECARRYOUT(CECARRYOUT),
    .OPMODE(OPMODE), .M(M), .DAB(DAB), .C(C),
    .PCIN(PCIN), .CARRYIN(CARRYIN),
    .P(p1), .PCOUT(pc1), .CARRYOUT(co1), .CARRYOUTF(cof1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string          tag;
    int             due;
    bit             d1;
    logic [W_P-1:0] p;
    logic           co;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_chk;
  int   n_pass;

  task automatic check(input string tag,
                       input logic [W_P-1:0] got,
                       input logic [W_P-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic expect_at(input string tag, input int lat,
                           input bit d1, input logic [W_P-1:0] p,
                           input logic co);
    exp_t e;
    e.tag = tag;
    e.due = cyc + lat;
    e.d1  = d1;
    e.p   = p;
    e.co  = co;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.due < cyc) begin
        check({e.tag, "_late"}, 48'(cyc), 48'(e.due));
      end else if (e.d1) begin
        check({e.tag, "_p"},     p1,   e.p);
        check({e.tag, "_pcout"}, pc1,  e.p);
        check({e.tag, "_co"},    48'(co1),  48'(e.co));
        check({e.tag, "_cof"},   48'(cof1), 48'(e.co));
      end else begin
        check({e.tag, "_p"},     p0,   e.p);
        check({e.tag, "_pcout"}, pc0,  e.p);
        check({e.tag, "_co"},    48'(co0),  48'(e.co));
        check({e.tag, "_cof"},   48'(cof0), 48'(e.co));
      end
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      cyc++;
      #1;
      drain();
    end
  endtask

  initial begin
    cyc = 0; n_chk = 0; n_pass = 0;
    rst = 1'b1;
    CEOPMODE = 1'b1; CECARRYIN = 1'b1;
    CEP = 1'b1; CECARRYOUT = 1'b1;
    OPMODE  = 8'($urandom);
    M       = 36'({$urandom, $urandom});
    DAB     = 48'({$urandom, $urandom});
    C       = 48'({$urandom, $urandom});
    PCIN    = 48'({$urandom, $urandom});
    CARRYIN = 1'($urandom);

    expect_at("rst", 2, 1'b0, '0, 1'b0);
    expect_at("rst1", 2, 1'b1, '0, 1'b0);
    step(2);

    rst = 1'b0; OPMODE = 8'h0D; M = 36'd5; C = 48'd100; CARRYIN = 1'b0;
    expect_at("lat1", 1, 1'b0, '0, 1'b0);
    expect_at("madd", 2, 1'b0, 48'd105, 1'b0);
    step(2);

    rst = 1'b1;
    expect_at("rst2", 1, 1'b0, '0, 1'b0);
    step(1);
    rst = 1'b0; OPMODE = 8'h09; M = 36'd3;
    expect_at("acc0", 1, 1'b0, '0, 1'b0);
    expect_at("acc3", 2, 1'b0, 48'd3, 1'b0);
    expect_at("acc6", 3, 1'b0, 48'd6, 1'b0);
    expect_at("acc9", 4, 1'b0, 48'd9, 1'b0);
    expect_at("acc12", 5, 1'b0, 48'd12, 1'b0);
    step(5);
    CEP = 1'b0;
    expect_at("hold", 1, 1'b0, 48'd12, 1'b0);
    step(1);
    CEP = 1'b1;
    expect_at("acc15", 1, 1'b0, 48'd15, 1'b0);
    step(1);
    rst = 1'b1;
    expect_at("midrst", 1, 1'b0, '0, 1'b0);
    step(1);
    rst = 1'b0;
    expect_at("re0", 1, 1'b0, '0, 1'b0);
    expect_at("re3", 2, 1'b0, 48'd3, 1'b0);
    step(2);

    OPMODE = 8'h8D; C = 48'd10; M = 36'd20;
    expect_at("sub", 2, 1'b0, 48'hFFFF_FFFF_FFF6, 1'b1);
    step(2);

    OPMODE = 8'h0D; C = 48'hFFFF_FFFF_FFFF; M = 36'd1;
    expect_at("wrap", 2, 1'b0, '0, 1'b1);
    step(2);

    CECARRYOUT = 1'b0; C = 48'd100; M = 36'd5;
    expect_at("cohold", 1, 1'b0, 48'd105, 1'b1);
    step(1);
    CECARRYOUT = 1'b1;

    CEOPMODE = 1'b0; OPMODE = 8'h00;
    expect_at("opmhold", 2, 1'b0, 48'd105, 1'b0);
    step(2);
    CEOPMODE = 1'b1;

    OPMODE = 8'hAD;
    expect_at("cin_lag", 2, 1'b0, 48'd95, 1'b0);
    expect_at("subcin", 3, 1'b0, 48'd94, 1'b0);
    step(3);

    OPMODE = 8'h07; DAB = 48'd1; PCIN = 48'd2; CARRYIN = 1'b1;
    expect_at("ext_cin", 2, 1'b1, 48'd4, 1'b0);
    expect_at("opm_cin_a", 2, 1'b0, 48'd4, 1'b0);
    expect_at("opm_cin_b", 3, 1'b0, 48'd3, 1'b0);
    expect_at("ext_cin_b", 3, 1'b1, 48'd4, 1'b0);
    step(3);

    check("sb_left", 48'(sb.size()), 48'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
